// File: rtl/jump_resolve_unit.sv
// jump_resolve_unit
//   Tracks the single in-flight jump/branch op from issue to completion and
//   resolves it from the functional unit's compare result and target.
//   Every taken jump redirects, because fetch always runs down the not-taken
//   path. The JAL/JALR link value goes out through a req/grant writeback
//   handshake.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   issue_en/op/rd   dispatch of a jump op (op: 00 BRANCH, 01 JAL, 10 JALR,
//                    11 reserved, handled as BRANCH); accepted only if !busy
//   kill             abort the in-flight op (ignored when idle)
//   fu_finish        FU result valid, carrying fu_cmp_res, fu_pc_jump, fu_pc_wb
//   busy             unit occupied (state != IDLE)
//   redirect_valid   1-cycle pulse, together with flush and redirect_pc
//   misalign_exc     1-cycle pulse, with exc_pc = the faulting target
//   wb_req/rd/data   link writeback request, held until wb_grant
//   fu_timeout       sticky: FU did not finish within FU_TIMEOUT cycles
module jump_resolve_unit #(
    parameter int XLEN       = 32,
    parameter int RD_W       = 5,
    parameter int FU_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_en,
    input  logic [1:0]      issue_op,
    input  logic [RD_W-1:0] issue_rd,
    input  logic            kill,
    input  logic            fu_finish,
    input  logic            fu_cmp_res,
    input  logic [XLEN-1:0] fu_pc_jump,
    input  logic [XLEN-1:0] fu_pc_wb,
    output logic            busy,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            misalign_exc,
    output logic [XLEN-1:0] exc_pc,
    output logic            wb_req,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    input  logic            wb_grant,
    output logic            fu_timeout
);

    localparam int CNT_W = (FU_TIMEOUT < 2) ? 1 : $clog2(FU_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(FU_TIMEOUT);
    localparam logic [1:0] OP_JAL  = 2'b01;
    localparam logic [1:0] OP_JALR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_FU, S_WB_REQ} state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              redir_q, redir_d;
    logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
    logic              mis_q, mis_d;
    logic [XLEN-1:0]   exc_pc_q, exc_pc_d;
    logic              wb_req_q, wb_req_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              to_q, to_d;

    // Resolution of the latched op against the current FU result.
    logic            is_jal, is_jalr, link, taken, mis;
    logic [XLEN-1:0] target;

    assign is_jal  = (op_q == OP_JAL);
    assign is_jalr = (op_q == OP_JALR);
    assign link    = is_jal | is_jalr;
    assign taken   = link | fu_cmp_res;
    assign target  = is_jalr ? {fu_pc_jump[XLEN-1:1], 1'b0} : fu_pc_jump;
    assign mis     = taken & target[1];
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        redir_d    = 1'b0;
        redir_pc_d = redir_pc_q;
        mis_d      = 1'b0;
        exc_pc_d   = exc_pc_q;
        wb_req_d   = wb_req_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        to_d       = to_q;

        case (state_q)
            S_IDLE: begin
                if (issue_en) begin
                    op_d    = issue_op;
                    rd_d    = issue_rd;
                    cnt_d   = '0;
                    state_d = S_WAIT_FU;
                end
            end
            S_WAIT_FU: begin
                cnt_d = cnt_inc;
                if (kill) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (fu_finish) begin
                    // A finish in the same cycle the timeout would fire still
                    // resolves: the FU did deliver its result.
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (taken) begin
                        // redirect_pc follows every taken target; consumers
                        // qualify it with redirect_valid.
                        redir_pc_d = target;
                        if (mis) begin
                            mis_d    = 1'b1;
                            exc_pc_d = target;
                        end else begin
                            redir_d  = 1'b1;
                        end
                    end
                    if (link && !mis && (rd_q != '0)) begin
                        wb_req_d  = 1'b1;
                        wb_rd_d   = rd_q;
                        wb_data_d = fu_pc_wb;
                        state_d   = S_WB_REQ;
                    end
                end else if ((FU_TIMEOUT != 0) && (cnt_inc == TO_VAL)) begin
                    to_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_WB_REQ: begin
                // A kill alongside a grant still counts as a completed write.
                if (kill || wb_grant) begin
                    wb_req_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                wb_req_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
            mis_q      <= 1'b0;
            exc_pc_q   <= '0;
            wb_req_q   <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            redir_q    <= redir_d;
            redir_pc_q <= redir_pc_d;
            mis_q      <= mis_d;
            exc_pc_q   <= exc_pc_d;
            wb_req_q   <= wb_req_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            to_q       <= to_d;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign redirect_valid = redir_q;
    assign flush          = redir_q;
    assign redirect_pc    = redir_pc_q;
    assign misalign_exc   = mis_q;
    assign exc_pc         = exc_pc_q;
    assign wb_req         = wb_req_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign fu_timeout     = to_q;

endmodule

// File: tb/tb_jump_resolve_unit.sv
module tb_jump_resolve_unit;

    localparam int K_REDIR = 0;
    localparam int K_EXC   = 1;
    localparam int K_WB    = 2;
    localparam logic [1:0] OP_BR = 2'b00, OP_JAL = 2'b01, OP_JALR = 2'b10, OP_RSV = 2'b11;

    typedef struct {
        int          kind;
        logic [31:0] val;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_en = 1'b0;
    logic [1:0]  issue_op = 2'b00;
    logic [4:0]  issue_rd = '0;
    logic        kill = 1'b0;
    logic        fu_finish = 1'b0;
    logic        fu_cmp_res = 1'b0;
    logic [31:0] fu_pc_jump = '0;
    logic [31:0] fu_pc_wb = '0;
    logic        wb_grant = 1'b0;
    logic        busy, redirect_valid, flush, misalign_exc, wb_req, fu_timeout;
    logic [31:0] redirect_pc, exc_pc, wb_data;
    logic [4:0]  wb_rd;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    jump_resolve_unit #(.XLEN(32), .RD_W(5), .FU_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_en(issue_en), .issue_op(issue_op), .issue_rd(issue_rd),
        .kill(kill), .fu_finish(fu_finish), .fu_cmp_res(fu_cmp_res),
        .fu_pc_jump(fu_pc_jump), .fu_pc_wb(fu_pc_wb),
        .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .misalign_exc(misalign_exc), .exc_pc(exc_pc),
        .wb_req(wb_req), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_grant(wb_grant), .fu_timeout(fu_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every pulse and every accepted writeback must match
    // the next expected event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (redirect_valid || misalign_exc) begin
                exp_t e;
                int   k;
                logic [31:0] v;
                k = redirect_valid ? K_REDIR : K_EXC;
                v = redirect_valid ? redirect_pc : exc_pc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_pulse kind %0d pc %h", k, v);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != k || e.val !== v || (redirect_valid && misalign_exc)) begin
                        errors++;
                        $display("FAIL sb_pulse got kind %0d pc %h exp kind %0d pc %h", k, v, e.kind, e.val);
                    end
                end
                checks++;
                if (flush !== redirect_valid) begin
                    errors++;
                    $display("FAIL sb_flush got %b exp %b", flush, redirect_valid);
                end
            end
            if (wb_req && wb_grant) begin
                exp_t e;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_wb rd %0d data %h", wb_rd, wb_data);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != K_WB || e.rd !== wb_rd || e.val !== wb_data) begin
                        errors++;
                        $display("FAIL sb_wb got rd %0d data %h exp kind %0d rd %0d data %h", wb_rd, wb_data, e.kind, e.rd, e.val);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [31:0] val, input logic [4:0] rd);
        exp_t e;
        e.kind = kind; e.val = val; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] rd);
        issue_en = 1'b1; issue_op = op; issue_rd = rd;
        tick();
        issue_en = 1'b0;
    endtask

    task automatic finish(input logic cmp, input logic [31:0] pj, input logic [31:0] pw);
        fu_finish = 1'b1; fu_cmp_res = cmp; fu_pc_jump = pj; fu_pc_wb = pw;
        tick();
        fu_finish = 1'b0; fu_cmp_res = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if ({busy, redirect_valid, flush, misalign_exc, wb_req, fu_timeout} !== 6'b0) begin errors++; $display("FAIL reset_ctl got %b exp 000000", {busy, redirect_valid, flush, misalign_exc, wb_req, fu_timeout}); end
        checks++; if ({redirect_pc, exc_pc, wb_data, wb_rd} !== 101'b0) begin errors++; $display("FAIL reset_data got %h %h %h %h exp 0", redirect_pc, exc_pc, wb_data, wb_rd); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_branch_taken();
        issue(OP_BR, 5'd3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL br_busy got %b exp 1", busy); end
        push(K_REDIR, 32'h100, 5'd0);
        finish(1'b1, 32'h100, 32'h104);
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin errors++; $display("FAIL br_redir got %b %h exp 1 00000100", redirect_valid, redirect_pc); end
        checks++; if (wb_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL br_idle got wb_req %b busy %b exp 0 0", wb_req, busy); end
        tick();
        checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'h100) begin errors++; $display("FAIL br_pulse_len got %b %b %h exp 0 0 00000100", redirect_valid, flush, redirect_pc); end
    endtask

    task automatic test_jalr();
        issue(OP_JALR, 5'd5);
        push(K_EXC, 32'h202, 5'd0);
        finish(1'b0, 32'h203, 32'h48);
        checks++; if (misalign_exc !== 1'b1 || exc_pc !== 32'h202 || redirect_pc !== 32'h202) begin errors++; $display("FAIL jalr_mis got %b %h %h exp 1 00000202 00000202", misalign_exc, exc_pc, redirect_pc); end
        checks++; if (redirect_valid !== 1'b0 || wb_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL jalr_mis_side got %b %b %b exp 0 0 0", redirect_valid, wb_req, busy); end
        tick();
        issue(OP_JALR, 5'd5);
        push(K_REDIR, 32'h200, 5'd0);
        push(K_WB, 32'h48, 5'd5);
        finish(1'b0, 32'h201, 32'h48);
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200 || misalign_exc !== 1'b0) begin errors++; $display("FAIL jalr_redir got %b %h %b exp 1 00000200 0", redirect_valid, redirect_pc, misalign_exc); end
        checks++; if (wb_req !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h48 || busy !== 1'b1) begin errors++; $display("FAIL jalr_wb got %b %0d %h %b exp 1 5 00000048 1", wb_req, wb_rd, wb_data, busy); end
        wb_grant = 1'b1;
        tick();
        wb_grant = 1'b0;
        checks++; if (wb_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL jalr_wb_done got %b %b exp 0 0", wb_req, busy); end
    endtask

    task automatic test_jal_stall();
        issue(OP_JAL, 5'd1);
        push(K_REDIR, 32'h300, 5'd0);
        push(K_WB, 32'h58, 5'd1);
        finish(1'b0, 32'h300, 32'h58);
        for (int i = 0; i < 3; i++) begin
            issue_en = 1'b1; issue_op = OP_JALR; issue_rd = 5'd7;
            tick();
            checks++; if (wb_req !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 32'h58 || busy !== 1'b1) begin errors++; $display("FAIL jal_stall%0d got %b %0d %h %b exp 1 1 00000058 1", i, wb_req, wb_rd, wb_data, busy); end
        end
        wb_grant = 1'b1;
        tick();
        wb_grant = 1'b0; issue_en = 1'b0;
        checks++; if (wb_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL jal_grant got %b busy %b exp 0 0", wb_req, busy); end
    endtask

    task automatic test_no_link();
        issue(OP_JAL, 5'd0);
        push(K_REDIR, 32'h400, 5'd0);
        finish(1'b0, 32'h400, 32'h44);
        checks++; if (redirect_valid !== 1'b1 || wb_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd0 got %b %b %b exp 1 0 0", redirect_valid, wb_req, busy); end
        tick();
        issue(OP_BR, 5'd2);
        finish(1'b0, 32'h500, 32'h50);
        checks++; if ({redirect_valid, misalign_exc, wb_req, busy} !== 4'b0 || redirect_pc !== 32'h400) begin errors++; $display("FAIL nt got %b %h exp 0000 00000400", {redirect_valid, misalign_exc, wb_req, busy}, redirect_pc); end
        tick();
        // reserved op behaves as a branch: no bit-0 clear, no link
        issue(OP_RSV, 5'd9);
        push(K_EXC, 32'h503, 5'd0);
        finish(1'b1, 32'h503, 32'h60);
        checks++; if (misalign_exc !== 1'b1 || exc_pc !== 32'h503 || wb_req !== 1'b0) begin errors++; $display("FAIL rsv got %b %h %b exp 1 00000503 0", misalign_exc, exc_pc, wb_req); end
        tick();
    endtask

    task automatic test_kill();
        kill = 1'b1;
        issue(OP_JAL, 5'd4);
        kill = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL kill_idle got busy %b exp 1", busy); end
        kill = 1'b1;
        finish(1'b1, 32'h600, 32'h64);
        kill = 1'b0;
        checks++; if ({redirect_valid, misalign_exc, wb_req, busy} !== 4'b0) begin errors++; $display("FAIL kill_fin got %b exp 0000", {redirect_valid, misalign_exc, wb_req, busy}); end
        tick();
        issue(OP_JAL, 5'd6);
        push(K_REDIR, 32'h700, 5'd0);
        finish(1'b0, 32'h700, 32'h74);
        checks++; if (wb_req !== 1'b1) begin errors++; $display("FAIL kill_wb_pre got %b exp 1", wb_req); end
        kill = 1'b1;
        tick();
        kill = 1'b0;
        checks++; if (wb_req !== 1'b0 || busy !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL kill_wb got %b %b %b exp 0 0 0", wb_req, busy, redirect_valid); end
        issue(OP_JALR, 5'd7);
        push(K_REDIR, 32'h710, 5'd0);
        push(K_WB, 32'h78, 5'd7);
        finish(1'b0, 32'h711, 32'h78);
        kill = 1'b1; wb_grant = 1'b1;
        tick();
        kill = 1'b0; wb_grant = 1'b0;
        checks++; if (wb_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL kill_grant got %b %b exp 0 0", wb_req, busy); end
    endtask

    task automatic test_timeout_and_reset();
        issue(OP_BR, 5'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (fu_timeout !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_early%0d got %b %b exp 0 1", i, fu_timeout, busy); end
        end
        tick();
        checks++; if (fu_timeout !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_fire got %b %b exp 1 0", fu_timeout, busy); end
        issue(OP_JAL, 5'd3);
        push(K_REDIR, 32'h800, 5'd0);
        finish(1'b0, 32'h800, 32'h84);
        tick();
        checks++; if (wb_req !== 1'b1 || fu_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got wb_req %b to %b exp 1 1", wb_req, fu_timeout); end
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, redirect_valid, flush, misalign_exc, wb_req, fu_timeout} !== 6'b0 || {redirect_pc, exc_pc, wb_data, wb_rd} !== 101'b0) begin errors++; $display("FAIL rst_mid got %b %h %h %h %h exp 0", {busy, redirect_valid, flush, misalign_exc, wb_req, fu_timeout}, redirect_pc, exc_pc, wb_data, wb_rd); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_branch_taken();
        test_jalr();
        test_jal_stall();
        test_no_link();
        test_kill();
        test_timeout_and_reset();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
